cla_seq_add32: RTL

CLA_SEQ_ADD32 -- requirements
Module: cla_seq_add32

---
 rtl/cla_seq_add32_pkg.sv | 19 +
 rtl/cla_seq_add32_cla4.sv | 30 +++
 rtl/cla_seq_add32.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cla_seq_add32_pkg.sv
// Shared constants, FSM encoding and helper for the nibble-serial CLA adder.
// Imported by the top level and the 4-bit lookahead cell.
package cla_seq_add32_pkg;

    localparam int NIB_DEFAULT = 8;
    localparam int NIB_BITS    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/cla_seq_add32_cla4.sv
// 4-bit carry-lookahead adder cell; all four carries are formed directly
// from generate/propagate terms and the carry-in.
module cla4
    import cla_seq_add32_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s  = p ^ c[3:0];
    assign co = c[4];

endmodule

// File: rtl/cla_seq_add32.sv
// Sequential W-bit adder/subtractor: one 4-bit CLA cell reused over NIB
// cycles, LSB nibble first, with the carry chained through a register.
module cla_seq_add32
    import cla_seq_add32_pkg::*;
#(
    parameter int NIB = NIB_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              op_sub,
    input  logic [4*NIB-1:0]  a,
    input  logic [4*NIB-1:0]  b,
    input  logic              ci,
    output logic              busy,
    output logic              done,
    output logic [4*NIB-1:0]  s,
    output logic              co,
    output logic              ovf
);

    localparam int W     = NIB_BITS * NIB;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     s_q, s_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    logic [W-1:0]     a_sh, b_sh;
    logic [3:0]       a_nib, b_nib, nib_s;
    logic             nib_co;

    // Nibble-select muxes on the latched operands.
    assign a_sh  = a_q >> {idx_q, 2'b00};
    assign b_sh  = b_q >> {idx_q, 2'b00};
    assign a_nib = a_sh[3:0];
    assign b_nib = b_sh[3:0];

    cla4 u_cla4 (
        .a  (a_nib),
        .b  (b_nib),
        .ci (carry_q),
        .s  (nib_s),
        .co (nib_co)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (idx_q == IDX_LAST) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = op_sub ? ~b : b;
                    carry_d = op_sub | ci;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                for (int n = 0; n < NIB; n++) begin
                    if (idx_q == IDX_W'(n)) s_d[4*n +: 4] = nib_s;
                end
                carry_d = nib_co;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    co_d  = nib_co;
                    ovf_d = signed_ovf(a_q[W-1], b_q[W-1], nib_s[3]);
                    idx_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    // Latched operands are pure data and need no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign s   = s_q;
    assign co  = co_q;
    assign ovf = ovf_q;

endmodule
